// File: rtl/rpn_sequencer.sv
// Program sequencer driving an external RPN calculator: loads a 19-bit program, steps it and
// tracks the expected stack depth. Define RPN_SEQ_CNT_CHECK_EN to verify calc_cnt in CHECK.
module rpn_sequencer #(
  parameter int unsigned PROG_DEPTH = 64,
  parameter int unsigned STACK_MAX  = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
  input  logic [18:0]                   prog_data,
  input  logic                          start,
  output logic                          calc_nrst,
  output logic                          calc_step,
  output logic                          calc_push,
  output logic [1:0]                    calc_op,
  output logic [15:0]                   calc_d,
  input  logic [15:0]                   calc_out,
  input  logic [9:0]                    calc_cnt,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [2:0]                    err_code,
  output logic [15:0]                   result,
  output logic [$clog2(PROG_DEPTH)-1:0] pc
);

  localparam int unsigned PW = $clog2(PROG_DEPTH);
  localparam int unsigned DW = $clog2(STACK_MAX + 1);
`ifdef RPN_SEQ_CNT_CHECK_EN
  localparam bit CntCheck = 1'b1;
`else
  localparam bit CntCheck = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, CLR, FETCH, ISSUE, STEP, CHECK, FIN, ERR} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pc_q, pc_d;
  logic [DW-1:0]   dep_q, dep_d;
  logic [15:0]     result_q, result_d;
  logic [2:0]      err_code_q, err_code_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            push_q, push_d;
  logic [1:0]      op_q, op_d;
  logic [15:0]     cd_q, cd_d;
  logic            nrst_q, step_q;
  logic [18:0]     word_q;
  logic [18:0]     mem [PROG_DEPTH];

  // Memory is not reset; the read port tracks pc every cycle, so the word is valid from ISSUE on.
  always_ff @(posedge clk) begin
    if (prog_we && state_q == IDLE) mem[prog_addr] <= prog_data;
    word_q <= mem[pc_q];
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    dep_d      = dep_q;
    result_d   = result_q;
    err_code_d = err_code_q;
    done_d     = done_q;
    error_d    = error_q;
    push_d     = push_q;
    op_d       = op_q;
    cd_d       = cd_q;
    case (state_q)
      IDLE:  if (start) state_d = CLR;
      CLR: begin
        pc_d       = '0;
        dep_d      = '0;
        done_d     = 1'b0;
        error_d    = 1'b0;
        err_code_d = '0;
        state_d    = FETCH;
      end
      FETCH: state_d = ISSUE;
      ISSUE: begin
        if (word_q[17:16] == 2'b00 && 32'(dep_q) == STACK_MAX) begin
          err_code_d = 3'd2;
          state_d    = ERR;
        end else if (word_q[17:16] == 2'b01 && dep_q == '0) begin
          err_code_d = 3'd1;
          state_d    = ERR;
        end else if (word_q[17] && 32'(dep_q) < 32'd2) begin
          err_code_d = 3'd1;
          state_d    = ERR;
        end else begin
          push_d  = (word_q[17:16] == 2'b00);
          op_d    = word_q[17:16];
          cd_d    = word_q[15:0];
          state_d = STEP;
        end
      end
      STEP: begin
        if (op_q == 2'b00)  dep_d = dep_q + DW'(1);
        else if (op_q[1])   dep_d = dep_q - DW'(1);
        state_d = CHECK;
      end
      CHECK: begin
        if (CntCheck && 32'(calc_cnt) != 32'(dep_q)) begin
          err_code_d = 3'd3;
          state_d    = ERR;
        end else if (word_q[18]) begin
          result_d = calc_out;
          state_d  = FIN;
        end else if (pc_q == PW'(PROG_DEPTH - 1)) begin
          err_code_d = 3'd4;
          state_d    = ERR;
        end else begin
          pc_d    = pc_q + PW'(1);
          state_d = FETCH;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        error_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      dep_q      <= '0;
      result_q   <= '0;
      err_code_q <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      push_q     <= 1'b0;
      op_q       <= '0;
      cd_q       <= '0;
      nrst_q     <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      dep_q      <= dep_d;
      result_q   <= result_d;
      err_code_q <= err_code_d;
      done_q     <= done_d;
      error_q    <= error_d;
      push_q     <= push_d;
      op_q       <= op_d;
      cd_q       <= cd_d;
      nrst_q     <= (state_d != CLR);
      step_q     <= (state_d == STEP);
    end
  end

  assign calc_nrst = nrst_q;
  assign calc_step = step_q;
  assign calc_push = push_q;
  assign calc_op   = op_q;
  assign calc_d    = cd_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = err_code_q;
  assign result    = result_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Scoreboard bench for rpn_sequencer with a behavioural calculator attached to its command port.
module tb_rpn_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prog_we = 1'b0;
  logic [5:0]  prog_addr = '0;
  logic [18:0] prog_data = '0;
  logic        start = 1'b0;
  logic        calc_nrst, calc_step, calc_push;
  logic [1:0]  calc_op;
  logic [15:0] calc_d, calc_out, result;
  logic [9:0]  calc_cnt;
  logic        busy, done, error;
  logic [2:0]  err_code;
  logic [5:0]  pc;

  always #5 clk = ~clk;

  rpn_sequencer #(.PROG_DEPTH(64), .STACK_MAX(1000)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .calc_nrst(calc_nrst), .calc_step(calc_step), .calc_push(calc_push),
    .calc_op(calc_op), .calc_d(calc_d), .calc_out(calc_out), .calc_cnt(calc_cnt),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .result(result), .pc(pc)
  );

  // Calculator model; ignore_push makes it drop pushes to provoke a depth mismatch.
  logic [15:0] stk [0:1023];
  int unsigned cnt = 0;
  bit          ignore_push = 1'b0;
  always @(posedge clk) begin
    if (!calc_nrst) cnt <= 0;
    else if (calc_step) begin
      if (calc_push) begin
        if (!ignore_push) begin
          stk[cnt] <= calc_d;
          cnt <= cnt + 1;
        end
      end else if (calc_op == 2'b01 && cnt >= 1) begin
        stk[cnt-1] <= 16'(-stk[cnt-1]);
      end else if (calc_op == 2'b10 && cnt >= 2) begin
        stk[cnt-2] <= 16'(stk[cnt-2] + stk[cnt-1]);
        cnt <= cnt - 1;
      end else if (calc_op == 2'b11 && cnt >= 2) begin
        stk[cnt-2] <= 16'(stk[cnt-2] * stk[cnt-1]);
        cnt <= cnt - 1;
      end
    end
  end
  assign calc_cnt = 10'(cnt);
  assign calc_out = (cnt == 0) ? 16'h0000 : stk[cnt-1];

  typedef struct {
    logic        done, error, nrst;
    logic [2:0]  code;
    logic [15:0] result;
    logic [5:0]  pc;
    int          steps, cycles;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(logic d, logic e, logic [2:0] c, logic [15:0] r, logic [5:0] p,
                              int s, int cy, logic n);
    exp_t x;
    x.done = d; x.error = e; x.code = c; x.result = r; x.pc = p;
    x.steps = s; x.cycles = cy; x.nrst = n;
    return x;
  endfunction

  // Monitor: a run ends when busy falls; compare the status it left behind with the queue head.
  int  bcyc = 0;
  int  nstep = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) bcyc++;
    if (calc_step === 1'b1) nstep++;
    if (prev_busy === 1'b1 && busy === 1'b0) begin
      if (q.size() == 0) chk("sb_unexpected_end", 32'(q.size()), 32'd1);
      else begin
        e = q.pop_front();
        chk("done", 32'(done), 32'(e.done));
        chk("error", 32'(error), 32'(e.error));
        chk("err_code", 32'(err_code), 32'(e.code));
        chk("result", 32'(result), 32'(e.result));
        chk("pc", 32'(pc), 32'(e.pc));
        chk("calc_nrst", 32'(calc_nrst), 32'(e.nrst));
        chk("steps", 32'(nstep), 32'(e.steps));
        chk("busy_cycles", 32'(bcyc), 32'(e.cycles));
      end
      bcyc  = 0;
      nstep = 0;
    end
    prev_busy = busy;
  end

  function automatic logic [18:0] ins(logic e, logic [1:0] op, logic [15:0] v);
    return {e, op, v};
  endfunction

  task automatic wr(input logic [5:0] a, input logic [18:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("timeout_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run(input int budget);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(budget);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_cmd", {12'd0, calc_step, calc_push, calc_op, calc_d}, 32'd0);
    chk("rst_nrst", 32'(calc_nrst), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("nrst_after_rst", 32'(calc_nrst), 32'd1);

    // 3 + 4 = 7
    wr(6'd0, ins(1'b0, 2'b00, 16'd3));
    wr(6'd1, ins(1'b0, 2'b00, 16'd4));
    wr(6'd2, ins(1'b1, 2'b10, 16'd0));
    q.push_back(mk(1, 0, 3'd0, 16'd7, 6'd2, 3, 14, 1));
    run(100);

    // -5
    wr(6'd0, ins(1'b0, 2'b00, 16'd5));
    wr(6'd1, ins(1'b1, 2'b01, 16'd0));
    q.push_back(mk(1, 0, 3'd0, 16'hFFFB, 6'd1, 2, 10, 1));
    run(100);

    // mul with one operand: underflow at pc 1, result kept from previous run
    wr(6'd0, ins(1'b0, 2'b00, 16'd2));
    wr(6'd1, ins(1'b1, 2'b11, 16'd0));
    q.push_back(mk(0, 1, 3'd1, 16'hFFFB, 6'd1, 1, 8, 1));
    run(100);

    // 64 pushes without END
    for (int i = 0; i < 64; i++) wr(6'(i), ins(1'b0, 2'b00, 16'(i)));
    q.push_back(mk(0, 1, 3'd4, 16'hFFFB, 6'd63, 64, 258, 1));
    run(400);

    // calculator that drops pushes
    ignore_push = 1'b1;
    wr(6'd0, ins(1'b0, 2'b00, 16'd1));
    wr(6'd1, ins(1'b1, 2'b00, 16'd2));
`ifdef RPN_SEQ_CNT_CHECK_EN
    q.push_back(mk(0, 1, 3'd3, 16'hFFFB, 6'd0, 1, 6, 1));
`else
    q.push_back(mk(1, 0, 3'd0, 16'h0000, 6'd1, 2, 10, 1));
`endif
    run(100);
    ignore_push = 1'b0;

    // abort with rst during STEP of the second instruction
    wr(6'd0, ins(1'b0, 2'b00, 16'd3));
    wr(6'd1, ins(1'b0, 2'b00, 16'd4));
    wr(6'd2, ins(1'b1, 2'b10, 16'd0));
    q.push_back(mk(0, 0, 3'd0, 16'd0, 6'd0, 2, 8, 0));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int s = 0;
      for (int i = 0; i < 50 && s < 2; i++) begin
        @(posedge clk); #1;
        if (calc_step) s++;
      end
      chk("abort_reached_step2", 32'(s), 32'd2);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_step", 32'(calc_step), 32'd0);
    chk("abort_nrst", 32'(calc_nrst), 32'd0);
    @(posedge clk); #1;

    // rerun; a write and a start pulse while busy must both be ignored
    q.push_back(mk(1, 0, 3'd0, 16'd7, 6'd2, 3, 14, 1));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    prog_we = 1'b1; prog_addr = 6'd2; prog_data = ins(1'b1, 2'b00, 16'd9); start = 1'b1;
    @(posedge clk); #1;
    prog_we = 1'b0; start = 1'b0;
    wait_idle(100);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1);
  end

endmodule

// File: doc/rpn_sequencer.md
RPN_SEQUENCER -- requirements
Module: rpn_sequencer

Interface
REQ-001 SHALL have parameter PROG_DEPTH, default 64: program memory entries; program counter is clog2(PROG_DEPTH) bits.
REQ-002 SHALL have parameter STACK_MAX, default 1000: stack depth capacity of the driven calculator.
REQ-003 SHALL have one clock and a synchronous, active-high reset; ports: clk in 1 (sole clock, rising edge); rst in 1 (synchronous, active-high reset).
REQ-004 SHALL have prog_we in 1: program write strobe.
REQ-005 SHALL have prog_addr in clog2(PROG_DEPTH): program write address.
REQ-006 SHALL have prog_data in 19: instruction word; [18]=END, [17:16]=op (00 push, 01 neg, 10 add, 11 mul), [15:0]=push operand.
REQ-007 SHALL have start in 1: begin execution at address 0.
REQ-008 SHALL have calc_nrst out 1: calculator reset, active low.
REQ-009 SHALL have calc_step out 1: calculator step strobe.
REQ-010 SHALL have calc_push out 1, calc_op out 2 and calc_d out 16: calculator command.
REQ-011 SHALL have calc_out in 16 and calc_cnt in 10: calculator top-of-stack and depth.
REQ-012 SHALL have busy out 1, done out 1, error out 1, err_code out 3, result out 16, pc out clog2(PROG_DEPTH): status.

Function
REQ-013 SHALL hold the program in a PROG_DEPTH x 19 memory with synchronous write on prog_we, accepted only when busy=0; writes while busy=1 SHALL be dropped.
REQ-014 SHALL read the program memory synchronously, with one cycle of latency.
REQ-015 SHALL implement FSM states IDLE, CLR, FETCH, ISSUE, STEP, CHECK, FIN, ERR.
REQ-016 SHALL go IDLE->CLR on start=1; start SHALL be ignored in every other state.
REQ-017 SHALL, in CLR, drive calc_nrst=0 for exactly one cycle, set pc=0 and expected depth dep=0, clear done, error and err_code, then go to FETCH.
REQ-018 SHALL, in FETCH, present pc to the memory and go to ISSUE.
REQ-019 SHALL, in ISSUE, validate the fetched word: push with dep==STACK_MAX -> ERR code 2; neg with dep<1 -> ERR code 1; add or mul with dep<2 -> ERR code 1; otherwise drive calc_push, calc_op and calc_d and go to STEP.
REQ-020 SHALL keep calc_push, calc_op and calc_d registered and stable from ISSUE through CHECK.
REQ-021 SHALL drive calc_step=1 only in STEP (one-cycle pulse, 0 elsewhere) and update dep in STEP: push +1, neg +0, add -1, mul -1.
REQ-022 SHALL, in CHECK, compare calc_cnt with dep when mismatch checking is compiled in (REQ-031); on inequality it SHALL go to ERR with code 3.
REQ-023 SHALL, in CHECK when the word had END=1, capture result<=calc_out and go to FIN.
REQ-024 SHALL, in CHECK when END=0 and pc==PROG_DEPTH-1, go to ERR with code 4 (no END, no wrap).
REQ-025 SHALL, in CHECK otherwise, increment pc and go to FETCH; a full instruction therefore takes 4 cycles.
REQ-026 SHALL, in FIN, set done=1 and return to IDLE; done SHALL remain 1 until the next start.
REQ-027 SHALL, in ERR, set error=1, latch err_code, freeze pc at the faulting instruction and return to IDLE; no calc_step SHALL be issued for the faulting word.
REQ-028 SHALL drive busy=1 in every state except IDLE.

Reset
REQ-029 SHALL, while rst=1 at a clk edge, force: state IDLE; pc, dep, result and err_code =0; busy, done, error, calc_step, calc_push =0; calc_op=0; calc_d=0; calc_nrst=0.
REQ-030 SHALL drive calc_nrst=1 in the cycle after rst deasserts (except in CLR); rst mid-run SHALL abort with no further calc_step; program memory contents SHALL not be cleared by rst.

Configuration
REQ-031 SHALL support macro RPN_SEQ_CNT_CHECK_EN: when defined, CHECK performs the calc_cnt==dep comparison and error code 3 is reachable; when undefined, CHECK performs no comparison, timing is unchanged, and code 3 never occurs.

Verification
REQ-032 SHALL cover: program {push 3, push 4, END add} with a model calculator -> 3 calc_step pulses, done=1, result=7, error=0, busy for 1+3x4+1 cycles.
REQ-033 SHALL cover: {push 5, END neg} -> result=0xFFFB, done=1.
REQ-034 SHALL cover: {push 2, END mul} -> error=1, err_code=1, pc=1, exactly 1 calc_step.
REQ-035 SHALL cover: a 64-entry program of push with no END -> err_code=4, pc=63.
REQ-036 SHALL cover: with RPN_SEQ_CNT_CHECK_EN, a calculator model that ignores push -> err_code=3 after the first push; without the macro -> no error.
REQ-037 SHALL cover: rst asserted during STEP of the second instruction -> next cycle busy=0, calc_nrst=0, calc_step=0; a later start reruns the same program to correct completion.
